// File: rtl/ps2_receive_pkg.sv
// ps2_pkg: shared PS/2 receiver states and frame constants
package ps2_pkg;
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic [7:0] ACK = 8'hFA;
  localparam int PKT_SYNC_BIT = 3;
endpackage

// File: rtl/ps2_receive_if.sv
// ps2_receive_if: PS/2 line inputs and received-byte outputs; packet signals exist only with PS2_RX_PACKET_EN
interface ps2_receive_if;
  logic PS2C, PS2D, enable;
  logic [7:0] data;
  logic valid, parity_err, frame_err, busy;
`ifdef PS2_RX_PACKET_EN
  logic [23:0] packet;
  logic packet_valid;
`endif
  modport master(output PS2C, PS2D, enable, input data, valid, parity_err, frame_err, busy
`ifdef PS2_RX_PACKET_EN
    , input packet, packet_valid
`endif
  );
  modport slave(input PS2C, PS2D, enable, output data, valid, parity_err, frame_err, busy
`ifdef PS2_RX_PACKET_EN
    , output packet, packet_valid
`endif
  );
endinterface

// File: rtl/ps2_receive_line_filter.sv
// ps2_line_filter: synchronises PS/2 clock/data, deglitches the clock and emits a falling-edge pulse
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic c_in,
  input  logic d_in,
  output logic d,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] cs, ds;
  logic filt;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip = (cs[1] != filt) && (cnt == CW'(FILTER_LEN - 1));
  assign d = ds[1];
  // filtered clock follows the synchronised line only after FILTER_LEN disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs <= 2'b11;
      ds <= 2'b11;
      filt <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      cs <= {cs[0], c_in};
      ds <= {ds[0], d_in};
      cnt <= (cs[1] == filt || flip) ? '0 : cnt + 1'b1;
      filt <= flip ? ~filt : filt;
      fall <= flip && filt;
    end
  end
endmodule

// File: rtl/ps2_receive.sv
// ps2_receive: PS/2 device-to-host deframer; PS2_RX_PACKET_EN adds 3-byte mouse packet assembly
module ps2_receive
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input logic qzt_clk,
  input logic reset,
  ps2_receive_if.slave bus
);
  logic d, fall;
  logic [1:0] state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n, data, data_n;
  logic par, par_n, valid, valid_n, perr, perr_n, ferr, ferr_n, busy;
  logic [CNT_W-1:0] cnt, cnt_n;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(qzt_clk), .rst(reset), .c_in(bus.PS2C), .d_in(bus.PS2D), .d(d), .fall(fall)
  );
  // frame FSM: enable abort beats a fall, a fall beats the inter-edge timeout
  always_comb begin
    state_n = state;
    idx_n = idx;
    shreg_n = shreg;
    par_n = par;
    cnt_n = cnt;
    data_n = data;
    valid_n = 1'b0;
    perr_n = 1'b0;
    ferr_n = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (fall) begin
      cnt_n = '0;
      case (state)
        IDLE: begin
          state_n = (d == START_BIT) ? DATA : IDLE;
          idx_n = 3'd0;
        end
        DATA: begin
          shreg_n[idx] = d;
          idx_n = idx + 3'd1;
          state_n = (idx == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n = d;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          ferr_n = (d != STOP_BIT);
          valid_n = (d == STOP_BIT) && ^{shreg, par};
          perr_n = (d == STOP_BIT) && !(^{shreg, par});
          data_n = valid_n ? shreg : data;
        end
      endcase
    end else if (state != IDLE) begin
      ferr_n = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
      state_n = ferr_n ? IDLE : state;
      cnt_n = ferr_n ? '0 : cnt + 1'b1;
    end
  end
  // register FSM state and one-cycle result pulses
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      cnt <= '0;
      data <= '0;
      valid <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      shreg <= shreg_n;
      par <= par_n;
      cnt <= cnt_n;
      data <= data_n;
      valid <= valid_n;
      perr <= perr_n;
      ferr <= ferr_n;
      busy <= (state_n != IDLE);
    end
  end
  assign bus.data = data;
  assign bus.valid = valid;
  assign bus.parity_err = perr;
  assign bus.frame_err = ferr;
  assign bus.busy = busy;
`ifdef PS2_RX_PACKET_EN
  logic [1:0] bcnt;
  logic [7:0] b0, b1;
  logic [23:0] packet;
  logic packet_valid;
  // collect three valid bytes, resyncing on a first byte without the sync bit or on any error
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      bcnt <= '0;
      b0 <= '0;
      b1 <= '0;
      packet <= '0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      if (perr || ferr || !bus.enable) begin
        bcnt <= '0;
      end else if (valid && (bcnt != 2'd0 || data[PKT_SYNC_BIT])) begin
        bcnt <= (bcnt == 2'd2) ? 2'd0 : bcnt + 2'd1;
        b0 <= (bcnt == 2'd0) ? data : b0;
        b1 <= (bcnt == 2'd1) ? data : b1;
        packet <= (bcnt == 2'd2) ? {data, b1, b0} : packet;
        packet_valid <= (bcnt == 2'd2);
      end
    end
  end
  assign bus.packet = packet;
  assign bus.packet_valid = packet_valid;
`endif
endmodule

// File: tb/tb_ps2_receive.sv
// tb_ps2_receive: randomized and directed PS/2 frames against a frame-level reference model
module tb_ps2_receive;
  localparam int FL = 8, TO = 400, HALF = 60;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  ps2_receive_if bus();
  ps2_receive #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .qzt_clk(clk), .reset(rst), .bus(bus)
  );
  int errors = 0, checks = 0;
  int nv = 0, np = 0, nf = 0, npk = 0, cyc = 0, ferr_cyc = 0, last_fall = 0;
  int bv, bp, bf, bpk, exp_npk = 0;
  logic [7:0] exp_data = 8'h00;
  logic [23:0] exp_pkt = '0;
  logic [7:0] pk[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.valid) nv++;
    if (bus.parity_err) np++;
    if (bus.frame_err) begin
      nf++;
      ferr_cyc = cyc;
    end
`ifdef PS2_RX_PACKET_EN
    if (bus.packet_valid) npk++;
`endif
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic snap();
    bv = nv; bp = np; bf = nf; bpk = npk;
  endtask
  function automatic void pkt_model(input bit ok, input logic [7:0] b);
    if (!ok) pk.delete();
    else if (pk.size() != 0 || b[3]) begin
      pk.push_back(b);
      if (pk.size() == 3) begin
        exp_pkt = {pk[2], pk[1], pk[0]};
        exp_npk++;
        pk.delete();
      end
    end
  endfunction
  task automatic send(input logic [10:0] f, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      bus.PS2D = f[i];
      wait_cyc(HALF);
      bus.PS2C = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      bus.PS2C = 1'b1;
      if (glitch && i == 4) begin
        wait_cyc(HALF / 4);
        bus.PS2C = 1'b0;
        wait_cyc(4);
        bus.PS2C = 1'b1;
        wait_cyc(HALF / 4);
      end
    end
    bus.PS2D = 1'b1;
  endtask
  task automatic check_pkt(input string tag);
    int e0 = exp_npk;
    check({tag, "_pkt_n"}, npk - bpk, e0 - bpk);
`ifdef PS2_RX_PACKET_EN
    if (npk != bpk) check({tag, "_pkt"}, bus.packet, exp_pkt);
`endif
  endtask
  task automatic frame(input string tag, input logic [7:0] b, input bit par, input bit stop, input bit glitch);
    bit ok, pe;
    int pk0;
    ok = stop && (^{b, par});
    pe = stop && !(^{b, par});
    snap();
    pk0 = exp_npk;
    pkt_model(ok, b);
    send({stop, par, b, 1'b0}, 11, glitch);
    wait_cyc(20);
    if (ok) exp_data = b;
    check({tag, "_valid"}, nv - bv, ok);
    check({tag, "_perr"}, np - bp, pe);
    check({tag, "_ferr"}, nf - bf, !stop);
    check({tag, "_data"}, bus.data, exp_data);
    check({tag, "_busy"}, bus.busy, 0);
`ifdef PS2_RX_PACKET_EN
    check({tag, "_pkt_n"}, npk - bpk, exp_npk - pk0);
    if (exp_npk != pk0) check({tag, "_pkt"}, bus.packet, exp_pkt);
`else
    check({tag, "_pkt_n"}, npk - bpk, 0);
`endif
  endtask
  initial begin
    bus.PS2C = 1'b1;
    bus.PS2D = 1'b1;
    bus.enable = 1'b1;
    wait_cyc(3);
    check("rst_data", bus.data, 8'h00);
    check("rst_valid", bus.valid, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    wait_cyc(5);
    frame("ack", 8'hFA, 1'b1, 1'b1, 1'b0);
    frame("bad_par", 8'h08, 1'b1, 1'b1, 1'b0);
    frame("bad_stop", 8'hAA, 1'b1, 1'b0, 1'b0);
    frame("good55", 8'h55, 1'b1, 1'b1, 1'b0);
    snap();
    send(11'b110_1010_1010, 4, 1'b0);
    wait_cyc(TO + 100);
    pkt_model(1'b0, 8'h00);
    check("to_ferr", nf - bf, 1);
    check("to_valid", nv - bv, 0);
    check("to_busy", bus.busy, 0);
    check("to_window", (ferr_cyc - last_fall >= TO) && (ferr_cyc - last_fall <= TO + FL + 8), 1);
    frame("after_to", 8'hFA, 1'b1, 1'b1, 1'b0);
    snap();
    bus.PS2C = 1'b0;
    wait_cyc(4);
    bus.PS2C = 1'b1;
    wait_cyc(30);
    check("idle_glitch_busy", bus.busy, 0);
    check("idle_glitch_pulses", (nv - bv) + (np - bp) + (nf - bf), 0);
    frame("mid_glitch", 8'hFA, 1'b1, 1'b1, 1'b1);
    snap();
    send(11'b110_0011_0110, 5, 1'b0);
    check("en_busy_pre", bus.busy, 1);
    bus.enable = 1'b0;
    wait_cyc(5);
    check("en_busy", bus.busy, 0);
    wait_cyc(TO + 50);
    bus.enable = 1'b1;
    pkt_model(1'b0, 8'h00);
    check("en_pulses", (nv - bv) + (np - bp) + (nf - bf), 0);
    frame("after_en", 8'h3C, 1'b1, 1'b1, 1'b0);
    send(11'b110_0101_0100, 6, 1'b0);
    #3 rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    exp_data = 8'h00;
    pk.delete();
    check("mid_rst_data", bus.data, 8'h00);
    check("mid_rst_busy", bus.busy, 0);
    frame("after_rst", 8'h55, 1'b1, 1'b1, 1'b0);
    frame("pk0", 8'h08, 1'b0, 1'b1, 1'b0);
    frame("pk1", 8'h05, 1'b1, 1'b1, 1'b0);
    frame("pk2", 8'hFB, 1'b0, 1'b1, 1'b0);
    frame("nosync", 8'h00, 1'b1, 1'b1, 1'b0);
    frame("nosync2", 8'h05, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      bit good, stop, gl;
      b = 8'($urandom);
      good = $urandom_range(0, 3) != 0;
      stop = $urandom_range(0, 7) != 0;
      gl = $urandom_range(0, 3) == 0;
      frame($sformatf("rnd%0d", i), b, good ? ~^b : ^b, stop, gl);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
